// File: rtl/switch_pkg.sv
// Shared types and constants for the switch allocation stage.
// Provides the default switch radix, the inport/outport index types and the
// width of the optional per-outport stall counters.
package switch_pkg;
  localparam int NUM_INPORTS_DEF  = 5;
  localparam int NUM_OUTPORTS_DEF = 5;
  localparam int IN_W_DEF         = $clog2(NUM_INPORTS_DEF);
  localparam int OUT_W_DEF        = $clog2(NUM_OUTPORTS_DEF);
  localparam int STATS_W          = 16;

  typedef logic [IN_W_DEF-1:0]  inport_t;
  typedef logic [OUT_W_DEF-1:0] outport_t;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin priority pick.
// Scans i_req upward starting at i_ptr (wrapping N-1 -> 0) and returns the
// first set request.
//   i_req  : request vector
//   i_ptr  : highest-priority position (must be < N)
//   o_gnt  : one-hot grant (zero when no request)
//   o_idx  : index of the granted request (zero when no request)
//   o_any  : at least one request was granted
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  int           c;
  logic [W-1:0] w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    c     = 0;
    w_c   = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(i_ptr) + k;
      if (c >= N) c = c - N;
      w_c = W'(c);
      if (!o_any && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-cycle crossbar arbitration with wormhole locking.
// Each outport grants at most one eligible inport per cycle, round-robin
// among unlocked requesters, and stays locked to the winning inport until
// that packet's tail flit is granted. Grants are combinational.
//   clk, n_rst   : clock, asynchronous active-low reset
//   req_valid    : inport has a flit ready
//   req_outport  : target outport per inport
//   req_tail     : flit is a tail (head+tail for single-flit packets)
//   req_ready    : downstream VC/buffer available for this flit
//   grant        : inport flit leaves its buffer this cycle
//   xbar_enable  : outport drives a flit this cycle
//   xbar_select  : inport routed to each outport (0 when idle)
//   stall_count  : per-outport stall counters, only with SWITCH_ALLOC_STATS_EN
// Optional feature macro: SWITCH_ALLOC_STATS_EN.
module switch_allocator
  import switch_pkg::*;
#(
  parameter int NUM_INPORTS  = NUM_INPORTS_DEF,
  parameter int NUM_OUTPORTS = NUM_OUTPORTS_DEF,
  parameter int OUT_W        = $clog2(NUM_OUTPORTS),
  parameter int IN_W         = $clog2(NUM_INPORTS)
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic [NUM_INPORTS-1:0]                 req_valid,
  input  logic [NUM_INPORTS-1:0][OUT_W-1:0]      req_outport,
  input  logic [NUM_INPORTS-1:0]                 req_tail,
  input  logic [NUM_INPORTS-1:0]                 req_ready,
  output logic [NUM_INPORTS-1:0]                 grant,
  output logic [NUM_OUTPORTS-1:0]                xbar_enable,
  output logic [NUM_OUTPORTS-1:0][IN_W-1:0]      xbar_select
`ifdef SWITCH_ALLOC_STATS_EN
  ,
  output logic [NUM_OUTPORTS-1:0][STATS_W-1:0]   stall_count
`endif
);
  logic [NUM_INPORTS-1:0]                    w_elig;
  logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0]  w_req;
  logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0]  w_gnt;

  // Out-of-range outports are compared one bit wider so a power-of-two
  // radix still works.
  always_comb begin
    w_elig = '0;
    w_req  = '0;
    for (int i = 0; i < NUM_INPORTS; i++) begin
      w_elig[i] = req_valid[i] && req_ready[i] &&
                  ({1'b0, req_outport[i]} < (OUT_W+1)'(NUM_OUTPORTS));
      for (int o = 0; o < NUM_OUTPORTS; o++)
        w_req[o][i] = w_elig[i] && (req_outport[i] == OUT_W'(o));
    end
  end

  // Each inport targets one outport, so OR-ing per-outport grants is safe.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) grant = grant | w_gnt[o];
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_out
    logic                   r_lock;
    logic [IN_W-1:0]        r_owner;
    logic [IN_W-1:0]        r_ptr;
    logic [NUM_INPORTS-1:0] w_rr_gnt;
    logic [IN_W-1:0]        w_rr_idx;
    logic                   w_rr_any;
    logic [NUM_INPORTS-1:0] w_g;
    logic [IN_W-1:0]        w_sel;
    logic                   w_en;

    rr_arbiter #(.N(NUM_INPORTS), .W(IN_W)) u_arb (
      .i_req (w_req[o]),
      .i_ptr (r_ptr),
      .o_gnt (w_rr_gnt),
      .o_idx (w_rr_idx),
      .o_any (w_rr_any)
    );

    // While reset is asserted no flit may leave, even if requests are held.
    always_comb begin
      w_g   = '0;
      w_sel = '0;
      w_en  = 1'b0;
      if (n_rst) begin
        if (r_lock) begin
          if (w_req[o][r_owner]) begin
            w_g[r_owner] = 1'b1;
            w_sel        = r_owner;
            w_en         = 1'b1;
          end
        end else if (w_rr_any) begin
          w_g   = w_rr_gnt;
          w_sel = w_rr_idx;
          w_en  = 1'b1;
        end
      end
    end

    assign w_gnt[o]       = w_g;
    assign xbar_enable[o] = w_en;
    assign xbar_select[o] = w_sel;

    // Pointer moves only on tail grants so a packet's body never reshuffles
    // priority.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_lock  <= 1'b0;
        r_owner <= '0;
        r_ptr   <= '0;
      end else if (w_en) begin
        if (req_tail[w_sel]) begin
          r_lock <= 1'b0;
          r_ptr  <= (w_sel == IN_W'(NUM_INPORTS-1)) ? '0 : w_sel + 1'b1;
        end else begin
          r_lock  <= 1'b1;
          r_owner <= w_sel;
        end
      end
    end

`ifdef SWITCH_ALLOC_STATS_EN
    logic [STATS_W-1:0] r_stall;
    logic               w_stall;

    assign w_stall = |(w_req[o] & ~w_g);

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                            r_stall <= '0;
      else if (w_stall && (r_stall != '1))   r_stall <= r_stall + 1'b1;
    end

    assign stall_count[o] = r_stall;
`endif
  end
endmodule
